// File: rtl/cache_refill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill_ctrl_pkg
// Brief    : Shared types and constants for the cache refill controller.
//            The refill FSM state type and line-offset helpers live here.
// Revision : 1.0 - initial release
// ============================================================================
package cache_refill_ctrl_pkg;

  // Refill sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    FILL    = 3'd4,
    DONE    = 3'd5
  } refill_state_t;

  // Byte-offset width of a line: word index bits plus two byte-in-word bits.
  function automatic int line_offset_bits(input int words);
    return $clog2(words) + 2;
  endfunction

  localparam int DEFAULT_LINE_WORDS = 4;
  localparam int LINE_OFFSET_BITS   = line_offset_bits(DEFAULT_LINE_WORDS);

endpackage
`default_nettype wire

// File: rtl/refill_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : refill_line_buffer
// Brief    : LINE_WORDS x DATA_WIDTH register file that assembles the line
//            being refilled. Word-indexed write port, flat packed read port
//            (word i at bits [i*DATA_WIDTH +: DATA_WIDTH]).
// Revision : 1.0 - initial release
// ============================================================================
module refill_line_buffer
  import cache_refill_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  localparam int IDX_W     = $clog2(LINE_WORDS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we_i,
  input  logic [IDX_W-1:0]               widx_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] line_o
);

  logic [DATA_WIDTH-1:0] words_q [LINE_WORDS];

  // Word storage: cleared on reset, one word written per enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        words_q[i] <= '0;
      end
    end else if (we_i) begin
      words_q[widx_i] <= wdata_i;
    end
  end

  generate
    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_pack
      assign line_o[g*DATA_WIDTH +: DATA_WIDTH] = words_q[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill_ctrl
// Brief    : Miss handler for the write-back data cache. Writes back a dirty
//            victim line, reads the missing line word by word from data
//            memory, then hands the assembled line to the cache with a
//            one-cycle fetch_enable pulse. Stalls the pipeline throughout.
//            Optional build macro REFILL_PERF_CNT_EN adds miss/write-back
//            event counters (miss_cnt_o, wb_cnt_o).
// Revision : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             miss_i,
  input  logic [DATA_WIDTH-1:0]            miss_addr_i,
  input  logic                             wb_valid_i,
  input  logic [DATA_WIDTH-1:0]            wb_addr_i,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] wb_data_i,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] fetch_data_o,
  output logic                             fetch_enable_o,
  output logic                             stall_o,
  output logic [DATA_WIDTH-1:0]            mem_addr_o,
  output logic                             mem_we_o,
  output logic                             mem_re_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
`ifdef REFILL_PERF_CNT_EN
  output logic [31:0]                      miss_cnt_o,
  output logic [31:0]                      wb_cnt_o,
`endif
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam int OFF_W = line_offset_bits(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

  refill_state_t         state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] line_addr_q;
  logic [DATA_WIDTH-1:0] wb_addr_q;
  logic [DATA_WIDTH-1:0] wb_word_q [LINE_WORDS];
  logic [DATA_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  mem_we_q;
  logic                  mem_re_q;
  logic                  fetch_en_q;

  logic [CNT_W-1:0]      cnt_inc;
  logic [DATA_WIDTH-1:0] next_off;
  logic [DATA_WIDTH-1:0] miss_line;
  logic                  buf_we;
  logic [CNT_W-1:0]      buf_idx;
  logic                  unused_offset_bits;

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign next_off  = {{(DATA_WIDTH-CNT_W-2){1'b0}}, cnt_inc, 2'b00};
  assign miss_line = {miss_addr_i[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  // Byte offset within the line is irrelevant to a refill.
  assign unused_offset_bits = ^miss_addr_i[OFF_W-1:0];

  // Read data lags mem_re by one cycle, so RD word k lands in slot k-1 and
  // RD_WAIT catches the final word.
  assign buf_we  = ((state_q == RD) && (cnt_q != '0)) || (state_q == RD_WAIT);
  assign buf_idx = (state_q == RD_WAIT) ? LAST_WORD : (cnt_q - CNT_W'(1));

  // Refill sequencer; memory-side strobes are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      line_addr_q <= '0;
      wb_addr_q   <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        wb_word_q[i] <= '0;
      end
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      fetch_en_q  <= 1'b0;
    end else begin
      fetch_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (miss_i) begin
            line_addr_q <= miss_line;
            cnt_q       <= '0;
            if (wb_valid_i) begin
              wb_addr_q <= wb_addr_i;
              for (int i = 0; i < LINE_WORDS; i++) begin
                wb_word_q[i] <= wb_data_i[i*DATA_WIDTH +: DATA_WIDTH];
              end
              mem_we_q    <= 1'b1;
              mem_addr_q  <= wb_addr_i;
              mem_wdata_q <= wb_data_i[DATA_WIDTH-1:0];
              state_q     <= WB;
            end else begin
              mem_re_q   <= 1'b1;
              mem_addr_q <= miss_line;
              state_q    <= RD;
            end
          end
        end
        WB: begin
          if (cnt_q == LAST_WORD) begin
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b1;
            mem_addr_q  <= line_addr_q;
            state_q     <= RD;
          end else begin
            cnt_q       <= cnt_inc;
            mem_addr_q  <= wb_addr_q + next_off;
            mem_wdata_q <= wb_word_q[cnt_inc];
          end
        end
        RD: begin
          if (cnt_q == LAST_WORD) begin
            cnt_q      <= '0;
            mem_re_q   <= 1'b0;
            mem_addr_q <= '0;
            state_q    <= RD_WAIT;
          end else begin
            cnt_q      <= cnt_inc;
            mem_addr_q <= line_addr_q + next_off;
          end
        end
        RD_WAIT: begin
          fetch_en_q <= 1'b1;
          state_q    <= FILL;
        end
        FILL: begin
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  refill_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buffer (
    .clk     (clk),
    .rst     (rst),
    .we_i    (buf_we),
    .widx_i  (buf_idx),
    .wdata_i (mem_rdata_i),
    .line_o  (fetch_data_o)
  );

  // Detection cycle stalls combinationally so the pipeline freezes at once.
  assign stall_o        = (state_q != IDLE) || miss_i;
  assign fetch_enable_o = fetch_en_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign mem_we_o       = mem_we_q;
  assign mem_re_o       = mem_re_q;

`ifdef REFILL_PERF_CNT_EN
  logic [31:0] miss_cnt_q;
  logic [31:0] wb_cnt_q;

  // Count refill starts; the counters wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else if ((state_q == IDLE) && miss_i) begin
      miss_cnt_q <= miss_cnt_q + 32'd1;
      if (wb_valid_i) begin
        wb_cnt_q <= wb_cnt_q + 32'd1;
      end
    end
  end

  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss-handling stage directly downstream of the 2-line, 4-word write-back data cache. On a cache miss it writes back the victim line if dirty, then reads the new line word-by-word from the backing data memory. It delivers the assembled line to the cache via fetch_data/fetch_enable and stalls the pipeline for the whole sequence.

Parameters:
DATA_WIDTH, 32, word width; also the address width.
LINE_WORDS, 4, words per cache line; must be a power of two ≥2; line offset = log2(LINE_WORDS)+2 bits.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
miss  in  1  cache access missed (access enable & !hit); level signal.
miss_addr  in  DATA_WIDTH  byte address of the missing access.
wb_valid  in  1  victim line is dirty and must be written back.
wb_addr  in  DATA_WIDTH  line-aligned victim address.
wb_data  in  LINE_WORDS*DATA_WIDTH  victim line; word i at bits [32i+31:32i].
fetch_data  out  LINE_WORDS*DATA_WIDTH  refilled line, same packing as wb_data.
fetch_enable  out  1  one-cycle pulse; cache installs fetch_data.
stall  out  1  freeze PC/pipeline; holds the cache address stable.
mem_addr  out  DATA_WIDTH  word address to data memory.
mem_we  out  1  memory write strobe (full word).
mem_re  out  1  memory read strobe.
mem_wdata  out  DATA_WIDTH  write data.
mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_re.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, word counter=0, line buffer=0.
- Outputs on reset: fetch_enable=0, stall=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, fetch_data=0.
- Reset mid-WB aborts the write-back immediately; no partial-line recovery.
- States: IDLE, WB, RD, RD_WAIT, FILL, DONE.
- IDLE:
  - miss=1 latches line address = miss_addr with the low offset bits cleared.
  - If wb_valid=1, also latches wb_addr/wb_data and goes to WB; otherwise goes to RD.
  - wb_* are sampled only in this cycle.
  - stall = miss (combinational), so it is high in the detection cycle.
- WB: LINE_WORDS cycles, counter k=0..N-1.
  - mem_we=1, mem_addr=wb_addr+4k, mem_wdata=word k.
  - After k=N-1: counter clears, go to RD.
- RD: LINE_WORDS cycles.
  - mem_re=1, mem_addr=line_addr+4k.
  - mem_rdata from the previous cycle is written to buffer word k-1.
  - After k=N-1: go to RD_WAIT.
- RD_WAIT: captures word N-1; mem_re=0; go to FILL.
- FILL: fetch_enable=1 for exactly one cycle; fetch_data=buffer (registered, stable from FILL until the next refill).
- DONE: one guard cycle so the cache hit flag updates. miss is ignored here; go to IDLE.
- stall=1 in every non-IDLE state.
- Latency, clean miss (detection = cycle 0): RD cycles 1–4, RD_WAIT 5, FILL 6, DONE 7, stall low in cycle 8.
- Latency, dirty miss: 4 cycles longer (WB cycles 1–4, FILL 10).
- mem_we and mem_re are never high together. Addresses are modulo 2^DATA_WIDTH; wrap is not checked.
- miss asserted outside IDLE is ignored. Re-assertion in the IDLE cycle after DONE starts a new refill.

Optional Feature:
REFILL_PERF_CNT_EN
- Defined: adds outputs miss_cnt and wb_cnt (32 bits each, reset 0, wrap at 2^32).
  - miss_cnt increments on each IDLE→WB or IDLE→RD transition.
  - wb_cnt increments on each IDLE→WB transition.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package: state enum refill_state_t (IDLE, WB, RD, RD_WAIT, FILL, DONE); constant LINE_OFFSET_BITS derived from LINE_WORDS.
- One natural sub-module, refill_line_buffer: LINE_WORDS×DATA_WIDTH register file with word-indexed write and a flat packed read port driving fetch_data.

Test Plan:
- Clean miss: miss=1, miss_addr=0x0000_1034, wb_valid=0; mem returns 0xA0+k.
  - mem_re at word addresses 0x1030/34/38/3C in cycles 1–4.
  - fetch_enable only in cycle 6 with fetch_data=0x000000A3_000000A2_000000A1_000000A0.
  - stall high in cycles 0–7.
- Dirty miss: wb_valid=1, wb_addr=0x0000_2010, wb_data words 0x11..0x44.
  - mem_we in cycles 1–4 to 0x2010..0x201C with 0x11,0x22,0x33,0x44.
  - Reads in cycles 5–8; fetch_enable in cycle 10.
  - mem_we and mem_re never both high.
- Miss held high throughout: exactly one refill; the new sequence starts only on the IDLE cycle after DONE (cycle 8).
- Reset pulse asynchronously during WB at k=2: mem_we, stall and fetch_enable drop before the next edge; no further memory writes; the next miss restarts from k=0.
- wb_valid toggled and miss_addr changed mid-RD: latched addresses and data are used; no effect on the bus.
- With REFILL_PERF_CNT_EN: one clean miss and two dirty misses → miss_cnt=3, wb_cnt=2; reset clears both counters to 0.
